// File: rtl/register_file_pkg.sv
// Shared register-file geometry plus the write-arbiter defaults and payload type.
package register_file_pkg;

  localparam int unsigned REG_COUNT    = 32;
  localparam int unsigned ADDR_WIDTH   = $clog2(REG_COUNT);
  localparam int unsigned DATA_WIDTH   = 32;
  localparam int unsigned LOCK_MAX_DEF = 8;

  // One requester's write payload.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/regfile_wr_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first valid requester at or after ptr_i wins.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         valid_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [NUM_REQ-1:0]         grant_o
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  // Walk the requesters in rotated order starting from the pointer.
  always_comb begin
    logic             found;
    logic [IDX_W:0]   pos;
    grant_o = '0;
    found   = 1'b0;
    pos     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      pos = {1'b0, ptr_i} + (IDX_W+1)'(i);
      if (pos >= (IDX_W+1)'(NUM_REQ)) begin
        pos = pos - (IDX_W+1)'(NUM_REQ);
      end
      if (!found && valid_i[pos[IDX_W-1:0]]) begin
        grant_o[pos[IDX_W-1:0]] = 1'b1;
        found                   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin write-port arbiter in front of the register file.
// Optional macro RF_ARB_LOCK_EN adds req_lock_i and a bounded grant-hold counter.
module regfile_wr_arbiter
  import register_file_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned LOCK_MAX = LOCK_MAX_DEF
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NUM_REQ-1:0]               req_valid_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data_i,
`ifdef RF_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]               req_lock_i,
`endif
  output logic [NUM_REQ-1:0]               req_ready_o,
  output logic                             we_o,
  output logic [ADDR_WIDTH-1:0]            waddr_o,
  output logic [DATA_WIDTH-1:0]            wdata_o,
  output logic [$clog2(NUM_REQ)-1:0]       grant_idx_o,
  output logic [15:0]                      drop_cnt_o
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  // Reject out-of-range configurations at elaboration.
  if (NUM_REQ < 2 || NUM_REQ > 8 || LOCK_MAX < 1) begin : g_bad_param
    $error("regfile_wr_arbiter: illegal NUM_REQ or LOCK_MAX");
  end

  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [IDX_W-1:0]      grant_idx_q, grant_idx_d;
  logic [15:0]           drop_cnt_q, drop_cnt_d;

  logic [NUM_REQ-1:0]    grant_c;
  logic [IDX_W-1:0]      gnt_idx_c;
  logic [IDX_W-1:0]      nxt_idx_c;
  logic                  xfer_c;
  wr_req_t               sel_c;

`ifdef RF_ARB_LOCK_EN
  localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
  logic [CNT_W-1:0] lock_inc_c;
  logic             lock_sel_c;
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .valid_i (req_valid_i),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant_c)
  );

  // Grants are suppressed while reset is held.
  assign req_ready_o = rst_i ? '0 : grant_c;
  assign xfer_c      = |req_ready_o;

  // Encode the one-hot grant and mux out the winner's payload.
  always_comb begin
    gnt_idx_c = '0;
    sel_c     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_c[i]) begin
        gnt_idx_c  = IDX_W'(i);
        sel_c.addr = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_c.data = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    nxt_idx_c = (gnt_idx_c == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_c + IDX_W'(1);
  end

  // Next-state: pointer advance, registered write port, dropped-write counter, lock hold.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    we_d        = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    grant_idx_d = grant_idx_q;
    drop_cnt_d  = drop_cnt_q;
    if (xfer_c) begin
      rr_ptr_d    = nxt_idx_c;
      we_d        = (sel_c.addr != '0);
      waddr_d     = sel_c.addr;
      wdata_d     = sel_c.data;
      grant_idx_d = gnt_idx_c;
      if (sel_c.addr == '0 && drop_cnt_q != 16'hFFFF) begin
        drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end
`ifdef RF_ARB_LOCK_EN
    lock_cnt_d = '0;
    lock_idx_d = lock_idx_q;
    lock_sel_c = |(req_lock_i & grant_c);
    lock_inc_c = (lock_idx_q == gnt_idx_c && lock_cnt_q != '0) ? lock_cnt_q + CNT_W'(1)
                                                               : CNT_W'(1);
    if (xfer_c && lock_sel_c) begin
      lock_idx_d = gnt_idx_c;
      // Parking the pointer on the holder keeps it granted while it stays valid.
      if (lock_inc_c != CNT_W'(LOCK_MAX)) begin
        lock_cnt_d = lock_inc_c;
        rr_ptr_d   = gnt_idx_c;
      end
    end
`endif
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q    <= '0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      grant_idx_q <= '0;
      drop_cnt_q  <= '0;
`ifdef RF_ARB_LOCK_EN
      lock_cnt_q  <= '0;
      lock_idx_q  <= '0;
`endif
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      grant_idx_q <= grant_idx_d;
      drop_cnt_q  <= drop_cnt_d;
`ifdef RF_ARB_LOCK_EN
      lock_cnt_q  <= lock_cnt_d;
      lock_idx_q  <= lock_idx_d;
`endif
    end
  end

  assign we_o        = we_q;
  assign waddr_o     = waddr_q;
  assign wdata_o     = wdata_q;
  assign grant_idx_o = grant_idx_q;
  assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter (NUM_REQ=4).
module tb_regfile_wr_arbiter;
  import register_file_pkg::*;

  localparam int unsigned NR = 4;
  localparam int unsigned AW = ADDR_WIDTH;
  localparam int unsigned DW = DATA_WIDTH;

  logic                 clk = 1'b0;
  logic                 rst_i = 1'b1;
  logic [NR-1:0]        req_valid_i = '0;
  logic [NR*AW-1:0]     req_addr_i = '0;
  logic [NR*DW-1:0]     req_data_i = '0;
`ifdef RF_ARB_LOCK_EN
  logic [NR-1:0]        req_lock_i = '0;
`endif
  logic [NR-1:0]        req_ready_o;
  logic                 we_o;
  logic [AW-1:0]        waddr_o;
  logic [DW-1:0]        wdata_o;
  logic [1:0]           grant_idx_o;
  logic [15:0]          drop_cnt_o;

  always #5 clk = ~clk;

  regfile_wr_arbiter #(.NUM_REQ(NR), .LOCK_MAX(8)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_addr_i  (req_addr_i),
    .req_data_i  (req_data_i),
`ifdef RF_ARB_LOCK_EN
    .req_lock_i  (req_lock_i),
`endif
    .req_ready_o (req_ready_o),
    .we_o        (we_o),
    .waddr_o     (waddr_o),
    .wdata_o     (wdata_o),
    .grant_idx_o (grant_idx_o),
    .drop_cnt_o  (drop_cnt_o)
  );

  typedef struct {
    logic             rst;
    logic [3:0]       valid;
    logic [3:0][AW-1:0] addr;
    logic [3:0]       exp_rdy;
  } vec_t;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [1:0]    idx;
    logic [15:0]   drop;
  } exp_t;

  exp_t              sb_q[$];
  int                n_tests = 0;
  int                n_fail  = 0;
  int                cur_row = 0;
  logic [3:0][AW-1:0] cur_addr = '0;
  logic [15:0]       exp_drop = '0;
  logic [AW-1:0]     last_addr = '0;
  logic [DW-1:0]     last_data = '0;
  logic [1:0]        last_idx  = '0;
  vec_t              vecs[21];

  function automatic logic [DW-1:0] data_of(input int row, input int n);
    return 32'hA5A5_0001 + 32'(row * 256) + 32'(n * 16);
  endfunction

  function automatic vec_t mk(input logic r, input logic [3:0] v,
                              input int a3, input int a2, input int a1, input int a0,
                              input logic [3:0] e);
    vec_t t;
    t.rst     = r;
    t.valid   = v;
    t.addr[3] = AW'(a3);
    t.addr[2] = AW'(a2);
    t.addr[1] = AW'(a1);
    t.addr[0] = AW'(a0);
    t.exp_rdy = e;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_payload();
    for (int n = 0; n < 4; n++) begin
      req_addr_i[n*AW +: AW] = cur_addr[n];
      req_data_i[n*DW +: DW] = data_of(cur_row, n);
    end
  endtask

  // One cycle: drive, check ready mid-cycle, push expectation, check registered outputs.
  task automatic step(input logic r, input logic [3:0] v, input logic [3:0] exp_rdy,
                      input string nm);
    exp_t e;
    int   n;
    rst_i       = r;
    req_valid_i = v;
    drive_payload();
    @(negedge clk);
    chk({nm, " ready"}, 64'(req_ready_o), 64'(exp_rdy));
    if (r) begin
      sb_q.delete();
      exp_drop  = '0;
      last_addr = '0;
      last_data = '0;
      last_idx  = '0;
    end else if (exp_rdy != 4'b0000) begin
      n = 0;
      for (int k = 0; k < 4; k++) if (exp_rdy[k]) n = k;
      e.addr = cur_addr[n];
      e.data = data_of(cur_row, n);
      e.idx  = 2'(n);
      e.we   = (e.addr != '0);
      if (e.addr == '0 && exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'd1;
      e.drop = exp_drop;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({nm, " we"},    64'(we_o),        64'(e.we));
      chk({nm, " waddr"}, 64'(waddr_o),     64'(e.addr));
      chk({nm, " wdata"}, 64'(wdata_o),     64'(e.data));
      chk({nm, " gidx"},  64'(grant_idx_o), 64'(e.idx));
      chk({nm, " drop"},  64'(drop_cnt_o),  64'(e.drop));
      last_addr = e.addr;
      last_data = e.data;
      last_idx  = e.idx;
    end else begin
      chk({nm, " idle we"},    64'(we_o),        64'(0));
      chk({nm, " idle waddr"}, 64'(waddr_o),     64'(last_addr));
      chk({nm, " idle wdata"}, 64'(wdata_o),     64'(last_data));
      chk({nm, " idle gidx"},  64'(grant_idx_o), 64'(last_idx));
      chk({nm, " idle drop"},  64'(drop_cnt_o),  64'(exp_drop));
    end
  endtask

  initial begin
    // Table: single write, round-robin sweep, dropped write, wrap-around, mid-stream reset.
    vecs[0]  = mk(1'b0, 4'b0001, 0, 0, 0, 5, 4'b0001);
    vecs[1]  = mk(1'b0, 4'b0000, 0, 0, 0, 5, 4'b0000);
    vecs[2]  = mk(1'b1, 4'b1111, 4, 3, 2, 1, 4'b0000);
    vecs[3]  = mk(1'b0, 4'b1111, 4, 3, 2, 1, 4'b0001);
    vecs[4]  = mk(1'b0, 4'b1111, 4, 3, 2, 1, 4'b0010);
    vecs[5]  = mk(1'b0, 4'b1111, 4, 3, 2, 1, 4'b0100);
    vecs[6]  = mk(1'b0, 4'b1111, 4, 3, 2, 1, 4'b1000);
    vecs[7]  = mk(1'b0, 4'b1111, 4, 3, 2, 1, 4'b0001);
    vecs[8]  = mk(1'b0, 4'b1111, 4, 3, 2, 1, 4'b0010);
    vecs[9]  = mk(1'b0, 4'b1111, 4, 3, 2, 1, 4'b0100);
    vecs[10] = mk(1'b0, 4'b1111, 4, 3, 2, 1, 4'b1000);
    vecs[11] = mk(1'b0, 4'b0100, 4, 0, 2, 1, 4'b0100);
    vecs[12] = mk(1'b0, 4'b0000, 4, 3, 2, 1, 4'b0000);
    vecs[13] = mk(1'b0, 4'b1000, 4, 3, 2, 1, 4'b1000);
    vecs[14] = mk(1'b0, 4'b0001, 4, 3, 2, 1, 4'b0001);
    vecs[15] = mk(1'b0, 4'b0000, 4, 3, 2, 1, 4'b0000);
    vecs[16] = mk(1'b0, 4'b1111, 4, 3, 2, 1, 4'b0010);
    vecs[17] = mk(1'b0, 4'b1111, 4, 3, 2, 1, 4'b0100);
    vecs[18] = mk(1'b1, 4'b1111, 4, 3, 2, 1, 4'b0000);
    vecs[19] = mk(1'b0, 4'b1110, 4, 3, 2, 1, 4'b0010);
    vecs[20] = mk(1'b0, 4'b0000, 4, 3, 2, 1, 4'b0000);

    // Initial reset with requests pending: no grants, outputs cleared.
    cur_addr = '0;
    step(1'b1, 4'b1111, 4'b0000, "reset0");
    step(1'b1, 4'b1111, 4'b0000, "reset1");

    for (int i = 0; i < 21; i++) begin
      string nm;
      cur_row  = i;
      cur_addr = vecs[i].addr;
      nm = $sformatf("row%0d", i);
      step(vecs[i].rst, vecs[i].valid, vecs[i].exp_rdy, nm);
    end

`ifdef RF_ARB_LOCK_EN
    // Locked requester 1 holds the grant for exactly LOCK_MAX transfers, then 2 gets a turn.
    cur_row  = 40;
    cur_addr = {AW'(4), AW'(3), AW'(2), AW'(1)};
    step(1'b1, 4'b1111, 4'b0000, "lock reset");
    req_lock_i = 4'b0010;
    step(1'b0, 4'b1111, 4'b0001, "lock g0");
    for (int k = 0; k < 8; k++) step(1'b0, 4'b1111, 4'b0010, $sformatf("lock hold%0d", k));
    step(1'b0, 4'b1111, 4'b0100, "lock release");
    req_lock_i = 4'b0000;
    step(1'b0, 4'b0000, 4'b0000, "lock idle");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
